// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: issues one sequential word fetch at a time and buffers
// returned {pc, instr} pairs in a circular queue drained by the decoder.
module instr_fetch_queue #(
  parameter int          IQ_SIZE      = 16,
  parameter int          IQ_INDEX_LEN = 4,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        if_read_or_not,
  output logic [31:0] intru_addr,
  input  logic        if_load_done,
  input  logic [31:0] mem_ctrl_instru_to_if,
  input  logic        jump_flag,
  input  logic [31:0] jump_addr,
  input  logic        iq_pop,
  output logic        iq_valid,
  output logic [31:0] iq_instr,
  output logic [31:0] iq_pc,
  output logic        iq_full
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FLUSH
  } state_t;

  localparam logic [IQ_INDEX_LEN:0] CNT_FULL = (IQ_INDEX_LEN + 1)'(IQ_SIZE);

  state_t                  state, state_nxt;
  logic [31:0]             pc, pc_nxt;
  logic                    req_nxt;
  logic [31:0]             addr_nxt;
  logic [IQ_INDEX_LEN-1:0] head, tail;
  logic [IQ_INDEX_LEN:0]   count;
  logic                    push, pop_ok, flush, has_room;

  logic [31:0] mem_pc    [IQ_SIZE];
  logic [31:0] mem_instr [IQ_SIZE];

  assign has_room = (count != CNT_FULL);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    req_nxt   = if_read_or_not;
    addr_nxt  = intru_addr;
    push      = 1'b0;
    flush     = 1'b0;
    pop_ok    = 1'b0;
    if (jump_flag) begin
      // Redirect overrides any pending reply or pop in the same cycle.
      flush     = 1'b1;
      state_nxt = S_FLUSH;
      req_nxt   = 1'b0;
      pc_nxt    = jump_addr;
      addr_nxt  = jump_addr;
    end else begin
      pop_ok = iq_pop && (count != '0);
      case (state)
        S_IDLE: begin
          if (has_room) begin
            req_nxt   = 1'b1;
            addr_nxt  = pc;
            state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          // Address stays put until the reply lands; the controller restarts on any change.
          if (if_load_done) begin
            push      = 1'b1;
            pc_nxt    = pc + 32'd4;
            req_nxt   = 1'b0;
            state_nxt = S_IDLE;
          end
        end
        S_FLUSH: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      if_read_or_not <= 1'b0;
      intru_addr     <= RESET_PC;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
    end else if (rdy_in) begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      if_read_or_not <= req_nxt;
      intru_addr     <= addr_nxt;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (pop_ok) head <= head + 1'b1;
        if (push)   tail <= tail + 1'b1;
        if (push && !pop_ok)      count <= count + 1'b1;
        else if (!push && pop_ok) count <= count - 1'b1;
      end
    end
  end

  // Queue storage carries data only, so it is left out of reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in && push) begin
      mem_pc[tail]    <= pc;
      mem_instr[tail] <= mem_ctrl_instru_to_if;
    end
  end

  assign iq_valid = (count != '0);
  assign iq_full  = (count == CNT_FULL);
  assign iq_instr = mem_instr[head];
  assign iq_pc    = mem_pc[head];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios followed by a randomized run
// checked against a queue-based reference of fetched {pc, word} pairs.
module tb_instr_fetch_queue;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, if_load_done, jump_flag, iq_pop;
  logic [31:0] mem_ctrl_instru_to_if, jump_addr;
  logic        if_read_or_not, iq_valid, iq_full;
  logic [31:0] intru_addr, iq_instr, iq_pc;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  always #5 clk_in = ~clk_in;

  instr_fetch_queue #(.IQ_SIZE(16), .IQ_INDEX_LEN(4), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .if_read_or_not(if_read_or_not),
    .intru_addr(intru_addr),
    .if_load_done(if_load_done),
    .mem_ctrl_instru_to_if(mem_ctrl_instru_to_if),
    .jump_flag(jump_flag),
    .jump_addr(jump_addr),
    .iq_pop(iq_pop),
    .iq_valid(iq_valid),
    .iq_instr(iq_instr),
    .iq_pc(iq_pc),
    .iq_full(iq_full)
  );

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!if_read_or_not && n < 6) begin
      tick();
      n++;
    end
    vectors++;
    if (if_read_or_not !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: no fetch request within %0d cycles (if_read_or_not=%0b, want 1)", tag, n, if_read_or_not);
    end
  endtask

  task automatic pulse_done(input logic [31:0] word);
    if_load_done = 1'b1;
    mem_ctrl_instru_to_if = word;
    tick();
    if_load_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    tick();
    tick();
    vectors++;
    if (if_read_or_not !== 1'b0 || intru_addr !== 32'h0 || iq_valid !== 1'b0 || iq_full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: req=%0b addr=%h valid=%0b full=%0b, want 0/00000000/0/0",
               if_read_or_not, intru_addr, iq_valid, iq_full);
    end
    rst_in = 1'b1;
    tick();
    vectors++;
    if (if_read_or_not !== 1'b1 || intru_addr !== 32'h0 || iq_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL first_fetch: req=%0b addr=%h valid=%0b, want 1/00000000/0", if_read_or_not, intru_addr, iq_valid);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wait_req("fill_req");
      vectors++;
      if (intru_addr !== 32'(i * 4)) begin
        miscompares++;
        $display("FAIL fill_addr: got %h, want %h", intru_addr, 32'(i * 4));
      end
      pulse_done(32'h0000_0013);
    end
    vectors++;
    if (iq_full !== 1'b1 || iq_valid !== 1'b1 || iq_pc !== 32'h0 || iq_instr !== 32'h13) begin
      miscompares++;
      $display("FAIL fill_full: full=%0b valid=%0b pc=%h instr=%h, want 1/1/00000000/00000013",
               iq_full, iq_valid, iq_pc, iq_instr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (if_read_or_not !== 1'b0) begin
        miscompares++;
        $display("FAIL full_no_fetch: req=%0b, want 0", if_read_or_not);
      end
    end
    iq_pop = 1'b1;
    tick();
    iq_pop = 1'b0;
    vectors++;
    if (iq_pc !== 32'h4 || iq_full !== 1'b0) begin
      miscompares++;
      $display("FAIL pop_one: pc=%h full=%0b, want 00000004/0", iq_pc, iq_full);
    end
    wait_req("refetch_req");
    vectors++;
    if (intru_addr !== 32'h40) begin
      miscompares++;
      $display("FAIL refetch_addr: got %h, want 00000040", intru_addr);
    end
    pulse_done(32'h0000_0013);
    iq_pop = 1'b1;
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (iq_valid !== 1'b1 || iq_pc !== 32'((k + 1) * 4)) begin
        miscompares++;
        $display("FAIL drain_pc: valid=%0b pc=%h, want 1/%h", iq_valid, iq_pc, 32'((k + 1) * 4));
      end
      tick();
    end
    iq_pop = 1'b0;
    vectors++;
    if (iq_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty: valid=%0b, want 0", iq_valid);
    end
  endtask

  task automatic test_wait_hold();
    wait_req("hold_req");
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (if_read_or_not !== 1'b1 || intru_addr !== 32'h44) begin
        miscompares++;
        $display("FAIL wait_hold: req=%0b addr=%h, want 1/00000044", if_read_or_not, intru_addr);
      end
      tick();
    end
    pulse_done(32'hDEAD_BEEF);
    vectors++;
    if (iq_valid !== 1'b1 || iq_pc !== 32'h44 || iq_instr !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL late_reply: valid=%0b pc=%h instr=%h, want 1/00000044/deadbeef", iq_valid, iq_pc, iq_instr);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      wait_req("flush_fill");
      pulse_done(32'h100 + 32'(i));
    end
    wait_req("flush_pending");
    if_load_done = 1'b1;
    mem_ctrl_instru_to_if = 32'h55;
    jump_flag = 1'b1;
    jump_addr = 32'h1000;
    iq_pop = 1'b1;
    tick();
    if_load_done = 1'b0;
    jump_flag = 1'b0;
    iq_pop = 1'b0;
    vectors++;
    if (iq_valid !== 1'b0 || if_read_or_not !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_clear: valid=%0b req=%0b, want 0/0", iq_valid, if_read_or_not);
    end
    wait_req("flush_refetch");
    vectors++;
    if (intru_addr !== 32'h1000 || iq_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_target: addr=%h valid=%0b, want 00001000/0", intru_addr, iq_valid);
    end
    pulse_done(32'h77);
    vectors++;
    if (iq_valid !== 1'b1 || iq_pc !== 32'h1000 || iq_instr !== 32'h77) begin
      miscompares++;
      $display("FAIL flush_first_push: valid=%0b pc=%h instr=%h, want 1/00001000/00000077", iq_valid, iq_pc, iq_instr);
    end
  endtask

  task automatic test_push_pop();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h1004;
    exp_pc[1] = 32'h1008;
    exp_pc[2] = 32'h100C;
    for (int i = 0; i < 2; i++) begin
      wait_req("pp_fill");
      pulse_done(32'h200 + 32'(i));
    end
    wait_req("pp_req");
    if_load_done = 1'b1;
    mem_ctrl_instru_to_if = 32'hA5;
    iq_pop = 1'b1;
    tick();
    if_load_done = 1'b0;
    for (int j = 0; j < 3; j++) begin
      vectors++;
      if (iq_valid !== 1'b1 || iq_pc !== exp_pc[j] || (j == 2 && iq_instr !== 32'hA5)) begin
        miscompares++;
        $display("FAIL push_pop_order: valid=%0b pc=%h instr=%h, want 1/%h", iq_valid, iq_pc, iq_instr, exp_pc[j]);
      end
      tick();
    end
    iq_pop = 1'b0;
    vectors++;
    if (iq_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL push_pop_count: valid=%0b, want 0", iq_valid);
    end
  endtask

  task automatic test_stall();
    wait_req("stall_req");
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if_load_done = (i == 1);
      mem_ctrl_instru_to_if = 32'hBAD;
      tick();
      vectors++;
      if (if_read_or_not !== 1'b1 || intru_addr !== 32'h1010 || iq_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold: req=%0b addr=%h valid=%0b, want 1/00001010/0", if_read_or_not, intru_addr, iq_valid);
      end
    end
    if_load_done = 1'b0;
    rdy_in = 1'b1;
    tick();
    vectors++;
    if (if_read_or_not !== 1'b1 || intru_addr !== 32'h1010) begin
      miscompares++;
      $display("FAIL stall_resume: req=%0b addr=%h, want 1/00001010", if_read_or_not, intru_addr);
    end
    pulse_done(32'h00C0_FFEE);
    vectors++;
    if (iq_valid !== 1'b1 || iq_pc !== 32'h1010 || iq_instr !== 32'h00C0_FFEE) begin
      miscompares++;
      $display("FAIL stall_complete: valid=%0b pc=%h instr=%h, want 1/00001010/00c0ffee", iq_valid, iq_pc, iq_instr);
    end
  endtask

  task automatic test_random();
    ent_t        q[$];
    logic [31:0] mpc, tmp;
    int          idle = 0;
    logic        last_rdy = 1'b1;
    logic        last_jump = 1'b0;
    jump_flag = 1'b1;
    jump_addr = 32'h8000;
    tick();
    jump_flag = 1'b0;
    mpc = 32'h8000;
    last_jump = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      vectors++;
      if (iq_valid !== (q.size() != 0) || iq_full !== (q.size() == 16)) begin
        miscompares++;
        $display("FAIL rand_flags cyc %0d: valid=%0b full=%0b, want size %0d", cyc, iq_valid, iq_full, q.size());
      end
      if (q.size() != 0) begin
        vectors++;
        if (iq_pc !== q[0].pc || iq_instr !== q[0].w) begin
          miscompares++;
          $display("FAIL rand_head cyc %0d: pc=%h instr=%h, want %h/%h", cyc, iq_pc, iq_instr, q[0].pc, q[0].w);
        end
      end
      if (if_read_or_not) begin
        vectors++;
        if (intru_addr !== mpc || q.size() >= 16) begin
          miscompares++;
          $display("FAIL rand_req cyc %0d: addr=%h size=%0d, want %h with room", cyc, intru_addr, q.size(), mpc);
        end
      end
      if (if_read_or_not || q.size() == 16 || (last_rdy && last_jump)) idle = 0;
      else if (last_rdy) idle++;
      vectors++;
      if (idle > 3) begin
        miscompares++;
        $display("FAIL rand_liveness cyc %0d: idle %0d cycles with room, want <=3", cyc, idle);
        idle = 0;
      end
      rdy_in    = ($urandom_range(0, 7) != 0);
      jump_flag = ($urandom_range(0, 39) == 0);
      tmp       = $urandom;
      jump_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : (tmp & 32'hFFFF_FFFC);
      iq_pop    = ((cyc / 200) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      if_load_done = if_read_or_not && ($urandom_range(0, 2) == 0);
      mem_ctrl_instru_to_if = $urandom;
      if (rdy_in) begin
        if (jump_flag) begin
          q.delete();
          mpc = jump_addr;
        end else begin
          if (iq_pop && q.size() > 0) void'(q.pop_front());
          if (if_read_or_not && if_load_done) begin
            q.push_back(ent_t'{mpc, mem_ctrl_instru_to_if});
            mpc = mpc + 32'd4;
          end
        end
      end
      last_rdy  = rdy_in;
      last_jump = jump_flag;
      tick();
    end
    rdy_in = 1'b1;
    jump_flag = 1'b0;
    iq_pop = 1'b0;
    if_load_done = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    if_load_done = 1'b0;
    mem_ctrl_instru_to_if = 32'h0;
    jump_flag = 1'b0;
    jump_addr = 32'h0;
    iq_pop = 1'b0;
    @(negedge clk_in);
    test_reset();
    test_fill();
    test_wait_hold();
    test_flush();
    test_push_pop();
    test_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage directly upstream of the memory controller's instruction port.
- Generates sequential PCs and issues one outstanding word fetch at a time.
- Pushes each returned instruction with its PC into a circular instruction queue, which the decoder pops.
- On a branch/flush redirect it discards queued and in-flight instructions and restarts at the redirect PC.

Parameters:
- IQ_SIZE, 16, number of queue entries (power of two).
- IQ_INDEX_LEN, 4, log2(IQ_SIZE); width of head/tail pointers.
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  synchronous, active-low reset.
- rdy_in  input  1  global stall; when 0, all registers hold.
- if_read_or_not  output  1  fetch request to memory controller.
- intru_addr  output  32  fetch address; stable while a request is pending.
- if_load_done  input  1  one-cycle pulse: mem_ctrl_instru_to_if is valid.
- mem_ctrl_instru_to_if  input  32  fetched instruction word.
- jump_flag  input  1  redirect/flush request.
- jump_addr  input  32  redirect target PC.
- iq_pop  input  1  decoder consumes head entry this cycle.
- iq_valid  output  1  queue non-empty.
- iq_instr  output  32  head instruction (combinational from head).
- iq_pc  output  32  head PC (combinational from head).
- iq_full  output  1  count == IQ_SIZE.

Behaviour:
- Reset (rst_in==0 at edge): pc=RESET_PC, state=IDLE, head=tail=0, count=0, if_read_or_not=0, intru_addr=RESET_PC. iq_valid=0, iq_full=0, iq_instr/iq_pc = head-entry contents (don't-care when iq_valid=0).
- rdy_in==0: no state, pointer, or output register changes. Inputs are ignored, including jump_flag and if_load_done.
- FSM states and transitions:
  - IDLE: if count + 1 <= IQ_SIZE (room for the reply), assert if_read_or_not=1 with intru_addr=pc, then go to WAIT. Otherwise stay in IDLE with if_read_or_not=0.
  - WAIT: hold if_read_or_not=1 and intru_addr constant. The controller restarts its byte counter if the address changes, so the address never changes mid-request. On if_load_done: push {pc, word} at tail, pc <= pc + 4 (32-bit wrap), deassert if_read_or_not, go to IDLE.
    - Minimum fetch-to-push latency is 1 cycle on a controller cache hit.
    - On a miss, latency is governed by the controller (≥6 cycles). Data-port traffic may stretch WAIT arbitrarily.
  - FLUSH: entered from any state on jump_flag. if_read_or_not=0 for exactly one cycle. Any if_load_done arriving in FLUSH is discarded. Next state is IDLE.
- Flush (jump_flag==1, rdy_in==1): head=tail=0, count=0, pc=jump_addr, intru_addr=jump_addr, state=FLUSH.
  - A push from a simultaneous if_load_done is dropped.
  - A simultaneous iq_pop is ignored.
  - Flush has priority over every other event.
- Queue rules:
  - Push writes at tail; tail <= tail + 1 mod IQ_SIZE.
  - Pop advances head mod IQ_SIZE.
  - count updates +1, -1, or 0 for push-only, pop-only, or both.
  - iq_pop while empty is ignored.
  - Simultaneous push and pop when full is impossible, because fetch only issues with room.
  - Simultaneous push and pop when empty: the pushed entry is not visible until the next cycle.
- Pointers wrap naturally at IQ_INDEX_LEN bits.
- Only one request is ever outstanding, so count never exceeds IQ_SIZE.

Test Plan:
- Reset with rst_in=0 for 2 cycles, then release -> if_read_or_not=1, intru_addr=0x0 on the first active cycle; iq_valid=0.
- Controller model returns 0x00000013 one cycle after each request, iq_pop=0 -> pushes PCs 0x0, 0x4, …, 0x3C. iq_full=1 after 16 entries. if_read_or_not stays 0 while full. Popping one entry re-issues at pc=0x40.
- WAIT held 8 cycles with no if_load_done -> intru_addr remains constant throughout. Returned 0xDEADBEEF is pushed with its correct PC.
- jump_flag=1, jump_addr=0x1000 in the same cycle as if_load_done, queue holding 5 entries -> queue empty next cycle. Returned word discarded. One idle cycle, then request at 0x1000.
- Simultaneous iq_pop and push at count=3 -> count stays 3. Head advances one entry; tail advances one entry.
- rdy_in=0 for 4 cycles during WAIT with if_load_done pulsed -> no push and no state change. The request completes normally after rdy_in returns to 1.
